// File: rtl/obi_ram_adapter_pkg.sv
// rtl/obi_ram_adapter_pkg.sv - shared types and constants for the OBI RAM adapter
//
// Holds the grant FSM state encoding, the stall LFSR tap mask and the
// default LFSR seed / stall mask used as parameter defaults.

package obi_ram_adapter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS          = 8'hB8;
    localparam logic [7:0] DEFAULT_LFSR_SEED  = 8'hA5;
    localparam logic [2:0] DEFAULT_STALL_MASK = 3'b011;

endpackage

// File: rtl/obi_stall_lfsr.sv
// rtl/obi_stall_lfsr.sv - 8-bit Fibonacci LFSR that supplies grant stall counts
//
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset, reloads SEED
//   advance_i  : shift the register by one step this cycle
//   state_o    : current LFSR contents

module obi_stall_lfsr
    import obi_ram_adapter_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       advance_i,
    output logic [7:0] state_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Shift left, XOR of the tapped bits enters at bit 0.
    always_comb begin
        lfsr_d = lfsr_q;
        if (advance_i) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/obi_ram_adapter.sv
// rtl/obi_ram_adapter.sv - OBI slave to single-port RAM adapter with optional pseudo-random grant stalls
//
// Optional feature macro: OBI_ADAPTER_STALL_EN (stall counts from obi_stall_lfsr;
// without it every request is granted in its own cycle).
//
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   req_i / gnt_o                : OBI request / combinational grant
//   addr_i, we_i, be_i, wdata_i  : OBI request payload, sampled in the grant cycle
//   rvalid_o, rdata_o, err_o     : OBI response, always one cycle after the grant
//   ram_en_o, ram_addr_o,
//   ram_we_o, ram_be_o,
//   ram_wdata_o                  : RAM access, driven in the grant cycle
//   ram_rdata_i                  : RAM read data, valid the cycle after the access

module obi_ram_adapter
    import obi_ram_adapter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [7:0]  LFSR_SEED  = DEFAULT_LFSR_SEED,
    parameter logic [2:0]  STALL_MASK = DEFAULT_STALL_MASK
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] stall_cnt;
    logic       gnt;
    logic       in_range;

    logic       rvalid_q;
    logic       rsp_rd_q;
    logic       rsp_err_q;

`ifdef OBI_ADAPTER_STALL_EN
    logic [7:0] lfsr_state;
    logic       unused_lfsr_hi;

    obi_stall_lfsr #(
        .SEED (LFSR_SEED)
    ) u_stall_lfsr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .advance_i (gnt),
        .state_o   (lfsr_state)
    );

    assign stall_cnt      = lfsr_state[2:0] & STALL_MASK;
    assign unused_lfsr_hi = ^lfsr_state[7:3];
`else
    logic unused_cfg;

    assign stall_cnt  = 3'd0;
    assign unused_cfg = ^{LFSR_SEED, STALL_MASK};
`endif

    assign in_range = (addr_i[31:ADDR_WIDTH] == '0);

    // A nonzero count N parks the request in STALL with the counter at N;
    // the grant comes in the STALL cycle where the counter reads 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (stall_cnt == 3'd0) begin
                        gnt = 1'b1;
                    end else begin
                        cnt_d   = stall_cnt;
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (!req_i) begin
                    // Abandoned request: the next one reloads the counter.
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == 3'd0) begin
                    gnt     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
        // Grant is combinational, so reset must mask it in the same cycle.
        if (rst_i) begin
            gnt = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            rvalid_q  <= 1'b0;
            rsp_rd_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= gnt;
            rsp_rd_q  <= gnt & in_range & ~we_i;
            rsp_err_q <= gnt & ~in_range;
        end
    end

    assign gnt_o       = gnt;
    assign ram_en_o    = gnt & in_range;
    assign ram_addr_o  = addr_i[ADDR_WIDTH-1:0];
    assign ram_we_o    = gnt & in_range & we_i;
    assign ram_be_o    = be_i;
    assign ram_wdata_o = wdata_i;

    // Read data is taken straight from the RAM in the response cycle.
    assign rvalid_o = rvalid_q;
    assign rdata_o  = (rvalid_q & rsp_rd_q) ? ram_rdata_i : 32'd0;
    assign err_o    = rvalid_q & rsp_err_q;

endmodule

// File: doc/obi_ram_adapter.md
OBI_RAM_ADAPTER -- requirements
Module: obi_ram_adapter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8: RAM byte-address width; byte addresses at or above 2**ADDR_WIDTH are out of range.
REQ-002 The block SHALL have parameter LFSR_SEED, default 8'hA5: stall LFSR reset value.
REQ-003 The block SHALL have parameter STALL_MASK, default 3'b011: mask applied to LFSR[2:0] to form the stall count.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req_i, input, 1 bit: OBI request.
REQ-007 The block SHALL have port gnt_o, output, 1 bit: OBI grant.
REQ-008 The block SHALL have port addr_i, input, 32 bits: OBI byte address.
REQ-009 The block SHALL have port we_i, input, 1 bit: write enable.
REQ-010 The block SHALL have port be_i, input, 4 bits: byte enables.
REQ-011 The block SHALL have port wdata_i, input, 32 bits: write data.
REQ-012 The block SHALL have port rvalid_o, output, 1 bit: response valid.
REQ-013 The block SHALL have port rdata_o, output, 32 bits: response data.
REQ-014 The block SHALL have port err_o, output, 1 bit: response error.
REQ-015 The block SHALL have port ram_en_o, output, 1 bit: RAM access strobe.
REQ-016 The block SHALL have port ram_addr_o, output, ADDR_WIDTH bits: RAM address.
REQ-017 The block SHALL have port ram_we_o, output, 1 bit: RAM write enable.
REQ-018 The block SHALL have port ram_be_o, output, 4 bits: RAM byte enables.
REQ-019 The block SHALL have port ram_wdata_o, output, 32 bits: RAM write data.
REQ-020 The block SHALL have port ram_rdata_i, input, 32 bits: RAM read data, valid one cycle after the RAM access.

Function
REQ-021 The block SHALL use FSM states IDLE and STALL.
- IDLE, req_i=1, stall count 0: assert gnt_o in that same cycle (combinational).
- IDLE, req_i=1, stall count N>0: load counter with N, go to STALL, gnt_o=0.
REQ-022 In STALL the counter SHALL decrement each cycle; when it reads 0, gnt_o=req_i, and on grant the FSM returns to IDLE.
REQ-023 If req_i drops while in STALL, the block SHALL return to IDLE without a grant; the next request draws a fresh stall count.
REQ-024 A grant SHALL occur only with req_i=1, and address, we, be and wdata SHALL be sampled in the grant cycle.
REQ-025 On an in-range grant (addr_i[31:ADDR_WIDTH]==0), the block SHALL drive ram_en_o=1 in the grant cycle, with ram_addr_o=addr_i[ADDR_WIDTH-1:0] and ram_we_o/ram_be_o/ram_wdata_o passed through from the request; otherwise ram_en_o=0 and ram_we_o=0.
REQ-026 On an out-of-range grant, the block SHALL not access the RAM.
REQ-027 rvalid_o SHALL be registered and assert exactly one cycle after every grant (fixed latency 1); back-to-back grants SHALL produce back-to-back rvalid_o.
REQ-028 Response data:
- In-range read: rdata_o=ram_rdata_i, err_o=0.
- Write: rdata_o=0, err_o=0.
- Out-of-range access: rdata_o=0, err_o=1.
- Whenever rvalid_o=0: rdata_o=0 and err_o=0.
REQ-029 The block SHALL support at most one outstanding transaction, which the fixed latency guarantees; no response buffering is required.

Reset
REQ-030 While rst_i=1, the block SHALL force the FSM to IDLE, the counter to 0, the LFSR to LFSR_SEED, and gnt_o, rvalid_o, err_o and ram_en_o to 0.
REQ-031 A reset asserted mid-STALL or in the grant cycle SHALL drop the transaction, with no rvalid_o following reset.

Configuration
REQ-032 With OBI_ADAPTER_STALL_EN defined:
- The stall count SHALL be LFSR[2:0] & STALL_MASK.
- The LFSR SHALL be 8-bit Fibonacci, taps 8,6,5,4, shifting left with the feedback entering bit 0.
- The LFSR SHALL advance once per grant.
REQ-033 Without OBI_ADAPTER_STALL_EN, the stall count SHALL be constantly 0, the LFSR SHALL be absent, and every request SHALL be granted in its own cycle.

Structure
REQ-034 Package obi_ram_adapter_pkg SHALL hold the FSM state enum, the LFSR tap constant, and the default seed and mask.
REQ-035 The LFSR SHALL be a sub-module named obi_stall_lfsr, instantiated only under OBI_ADAPTER_STALL_EN.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- Macro off: write 0xDEADBEEF, be 4'hF, to 0x10; then read 0x10 -> gnt same cycle as req; rvalid one cycle later; rdata 0xDEADBEEF, err 0.
- Macro off: byte write 0x000000AA, be 4'h1, to 0x20 over 0x11223344; then read -> rdata 0x112233AA.
- Address 0x0000_0400 with ADDR_WIDTH=8 -> ram_en_o=0; rvalid with err 1, rdata 0.
- Macro on, seed 8'hA5 -> first request stalls (0xA5[2:0]&3)=1 cycle; following stalls match the reference LFSR model.
- req dropped mid-STALL, then reasserted -> no grant while low; new stall count drawn; single rvalid.
- rst_i pulsed during STALL -> gnt 0, rvalid 0 the next cycle; LFSR back to 0xA5.
